// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: zero-latency pipeline writeback path plus a one-entry
// holding register for a long-latency aux writer, with starvation-forced aux grants.
module wb_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [4:0]        pipe_rd,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [4:0]        aux_rd,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              aux_busy,
  output logic [4:0]        aux_busy_rd
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [4:0]        hold_rd_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              held, pwe, waw, load;

  // Writes to x0 are architecturally void, so they never compete for the port.
  assign pwe         = pipe_we & (pipe_rd != 5'd0);
  assign held        = (state_q != IDLE);
  assign waw         = held & pwe & (pipe_rd == hold_rd_q);
  assign aux_ready   = ~held & ~rst;
  assign load        = aux_valid & aux_ready & (aux_rd != 5'd0);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign aux_busy    = held;
  assign aux_busy_rd = held ? hold_rd_q : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) hold_rd_q <= aux_rd;
    end
  end

  // Payload needs no reset: it is only observed while held is set.
  always_ff @(posedge clk) begin
    if (load) hold_data_q <= aux_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (waw || !pwe) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_MAX) state_d = FORCE;
        end
      end
      FORCE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A younger pipeline write to the held rd wins outright, even over a forced grant.
  always_comb begin
    rf_we      = 1'b0;
    rf_rd      = pipe_rd;
    rf_wdata   = pipe_wdata;
    pipe_stall = 1'b0;
    case (state_q)
      IDLE: rf_we = pwe;
      WAIT: begin
        rf_we = 1'b1;
        if (!pwe) begin
          rf_rd    = hold_rd_q;
          rf_wdata = hold_data_q;
        end
      end
      FORCE: begin
        rf_we = 1'b1;
        if (!waw) begin
          rf_rd      = hold_rd_q;
          rf_wdata   = hold_data_q;
          pipe_stall = pwe;
        end
      end
      default: rf_we = 1'b0;
    endcase
    if (rst) begin
      rf_we      = 1'b0;
      pipe_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed vectors with queued expected writes,
// then random traffic checked against an architectural regfile model.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd;
  logic [31:0] aux_wdata;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        aux_busy;
  logic [4:0]  aux_busy_rd;

  wb_port_arbiter #(.DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_wdata(aux_wdata),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .aux_busy(aux_busy), .aux_busy_rd(aux_busy_rd)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        stall;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          mode = 0;
  logic [31:0] exp_rf [32];
  logic [31:0] got_rf [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void push(logic [4:0] rd, logic [31:0] data, logic stall);
    exp_t e;
    e.rd = rd; e.data = data; e.stall = stall;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: pops expected writes in directed mode, fills a shadow regfile in random mode.
  initial begin
    logic prev_stall;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pipe_stall) begin
          check("stall_while_held", 32'(aux_busy), 32'd1);
          check("stall_back_to_back", 32'(prev_stall), 32'd0);
          check("stall_with_write", 32'(rf_we), 32'd1);
        end
        if (rf_we) begin
          if (mode == 0) begin
            if (sb.size() == 0) begin
              check("unexpected_write_rd", 32'(rf_rd), 32'h0000_dead);
            end else begin
              e = sb.pop_front();
              check("write_rd", 32'(rf_rd), 32'(e.rd));
              check("write_data", rf_wdata, e.data);
              check("write_stall", 32'(pipe_stall), 32'(e.stall));
            end
          end else begin
            got_rf[rf_rd] = rf_wdata;
          end
        end
        prev_stall = pipe_stall;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic stalled;
    logic acc;
    for (int i = 0; i < 32; i++) begin
      exp_rf[i] = '0;
      got_rf[i] = '0;
    end
    rst = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'h1234;
    aux_valid = 1'b1; aux_rd = 5'd2; aux_wdata = 32'h5678;
    tick(); tick();
    sample();
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_stall", 32'(pipe_stall), 32'd0);
    check("rst_aux_ready", 32'(aux_ready), 32'd0);
    tick();
    rst = 1'b0; pipe_we = 1'b0; aux_valid = 1'b0;
    sample();
    check("idle_aux_ready", 32'(aux_ready), 32'd1);
    check("idle_aux_busy", 32'(aux_busy), 32'd0);
    check("idle_aux_busy_rd", 32'(aux_busy_rd), 32'd0);
    check("idle_rf_we", 32'(rf_we), 32'd0);
    tick();

    // Aux result reaches the port one cycle after acceptance.
    aux_valid = 1'b1; aux_rd = 5'd5; aux_wdata = 32'hDEAD;
    push(5'd5, 32'hDEAD, 1'b0);
    sample();
    check("t1_accept_ready", 32'(aux_ready), 32'd1);
    tick();
    aux_valid = 1'b0;
    sample();
    check("t1_held_ready", 32'(aux_ready), 32'd0);
    check("t1_busy", 32'(aux_busy), 32'd1);
    check("t1_busy_rd", 32'(aux_busy_rd), 32'd5);
    tick();
    sample();
    check("t1_ready_back", 32'(aux_ready), 32'd1);
    check("t1_busy_clear", 32'(aux_busy), 32'd0);
    tick();

    // Starvation: four pipe writes, one forced aux write with stall, pipe value replayed.
    aux_valid = 1'b1; aux_rd = 5'd7; aux_wdata = 32'h77;
    sample();
    tick();
    aux_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd3;
    for (int k = 0; k < 6; k++) begin
      pipe_wdata = (k < 5) ? 32'h30 + 32'(k) : 32'h34;
      if (k < 4)       push(5'd3, 32'h30 + 32'(k), 1'b0);
      else if (k == 4) push(5'd7, 32'h77, 1'b1);
      else             push(5'd3, 32'h34, 1'b0);
      sample();
      if (k == 4) check("t2_force_stall", 32'(pipe_stall), 32'd1);
      tick();
    end
    pipe_we = 1'b0;
    sample();
    check("t2_busy_clear", 32'(aux_busy), 32'd0);
    tick();

    // WAW: younger pipe write to the held rd discards the aux entry.
    aux_valid = 1'b1; aux_rd = 5'd9; aux_wdata = 32'h99;
    sample();
    tick();
    aux_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd9; pipe_wdata = 32'h1;
    push(5'd9, 32'h1, 1'b0);
    sample();
    tick();
    pipe_we = 1'b0;
    sample();
    check("t3_busy_clear", 32'(aux_busy), 32'd0);
    repeat (3) tick();

    // x0 traffic: aux result dropped, pipe write suppressed.
    aux_valid = 1'b1; aux_rd = 5'd0; aux_wdata = 32'hBAD;
    sample();
    check("t4_x0_ready", 32'(aux_ready), 32'd1);
    tick();
    aux_valid = 1'b0;
    sample();
    check("t4_x0_not_held", 32'(aux_busy), 32'd0);
    check("t4_x0_ready_after", 32'(aux_ready), 32'd1);
    tick();
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wdata = 32'h5;
    sample();
    check("t4_pipe_x0_we", 32'(rf_we), 32'd0);
    tick();
    pipe_we = 1'b0;

    // Reset while an entry is held: entry lost, no write.
    aux_valid = 1'b1; aux_rd = 5'd4; aux_wdata = 32'h44;
    sample();
    tick();
    aux_valid = 1'b0; rst = 1'b1;
    sample();
    check("t5_rst_rf_we", 32'(rf_we), 32'd0);
    tick();
    rst = 1'b0;
    sample();
    check("t5_ready", 32'(aux_ready), 32'd1);
    check("t5_busy", 32'(aux_busy), 32'd0);
    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Random traffic: model applies pipe then aux in issue order per cycle.
    mode = 1;
    stalled = 1'b0;
    acc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!stalled) begin
        pipe_we    = 1'($urandom_range(0, 1));
        pipe_rd    = 5'($urandom_range(0, 7));
        pipe_wdata = $urandom;
      end
      if (!aux_valid || acc) begin
        aux_valid = ($urandom_range(0, 2) == 0);
        aux_rd    = 5'($urandom_range(0, 7));
        aux_wdata = $urandom;
      end
      sample();
      stalled = pipe_stall;
      acc     = aux_valid & aux_ready;
      if (pipe_we && pipe_rd != 5'd0 && !pipe_stall) exp_rf[pipe_rd] = pipe_wdata;
      if (acc && aux_rd != 5'd0) exp_rf[aux_rd] = aux_wdata;
      tick();
    end
    pipe_we = 1'b0; aux_valid = 1'b0;
    for (int w = 0; w < 10; w++) begin
      sample();
      if (!aux_busy) break;
      tick();
    end
    check("rand_drain_busy", 32'(aux_busy), 32'd0);
    tick();
    for (int r = 0; r < 32; r++) begin
      check($sformatf("rand_rf_x%0d", r), got_rf[r], exp_rf[r]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
